// File: rtl/timer_compare.sv
// ----------------------------------------------------------------------------
// timer_compare
//   Bus-mapped compare timer driven by the free-running tick count from the
//   hardware clock block. Raises a level interrupt when time_in reaches the
//   programmed compare value. Supports one-shot and periodic modes and stays
//   correct across the W-bit tick rollover.
//
//   Optional feature macro: TIMER_CAPTURE_EN
//     When defined, adds the capture_in port (2-flop synchronised) that
//     snapshots time_in into CAP on a rising edge and sets STATUS.cap_valid.
//     When undefined, CAP and STATUS.cap_valid read as 0.
//
// Ports
//   clk        in   1    system clock
//   rst        in   1    asynchronous, active-high reset
//   time_in    in   W    tick count (+1 per tick, wraps)
//   bus_wen    in   1    write strobe
//   bus_ren    in   1    read strobe
//   bus_addr   in   AW   word address
//   bus_wdata  in   W    write data
//   bus_rdata  out  W    read data, registered, valid the cycle after bus_ren
//   irq        out  1    level interrupt = STATUS.pending
//   capture_in in   1    async capture request (TIMER_CAPTURE_EN only)
//
// Register map (word index)
//   0 CMP rw | 1 PERIOD rw | 2 CTRL rw {b1 periodic, b0 en}
//   3 STATUS w1c {b2 cap_valid, b1 overrun, b0 pending}
//   4 NOW ro (time_in) | 5 CAP ro | 6,7 read 0
// ----------------------------------------------------------------------------
module timer_compare #(
    parameter int W  = 32,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  time_in,
    input  logic          bus_wen,
    input  logic          bus_ren,
    input  logic [AW-1:0] bus_addr,
    input  logic [W-1:0]  bus_wdata,
    output logic [W-1:0]  bus_rdata,
    output logic          irq
`ifdef TIMER_CAPTURE_EN
    ,
    input  logic          capture_in
`endif
);

    localparam logic [AW-1:0] A_CMP    = AW'(0);
    localparam logic [AW-1:0] A_PERIOD = AW'(1);
    localparam logic [AW-1:0] A_CTRL   = AW'(2);
    localparam logic [AW-1:0] A_STATUS = AW'(3);
    localparam logic [AW-1:0] A_NOW    = AW'(4);
    localparam logic [AW-1:0] A_CAP    = AW'(5);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRED = 2'd2
    } state_t;

    state_t          state_q;
    logic [W-1:0]    cmp_q;
    logic [W-1:0]    period_q;
    logic [1:0]      ctrl_q;      // {periodic, en}
    logic            pending_q;
    logic            overrun_q;
    logic [W-1:0]    rdata_q;

    logic [W-1:0]    rdata_d;
    logic            wr_cmp;
    logic            wr_period;
    logic            wr_ctrl;
    logic            wr_status;
    logic signed [W-1:0] delta;
    logic            due;
    logic            cap_valid_w;
    logic [W-1:0]    cap_w;

    // ------------------------------------------------------------------
    // Optional capture path
    // ------------------------------------------------------------------
`ifdef TIMER_CAPTURE_EN
    logic         cap_s1_q;
    logic         cap_s2_q;
    logic         cap_s3_q;
    logic [W-1:0] cap_q;
    logic         cap_valid_q;
    logic         cap_rise;

    // s1/s2 synchronise; s3 holds the previous synced level for edge detect
    assign cap_rise    = cap_s2_q & ~cap_s3_q;
    assign cap_valid_w = cap_valid_q;
    assign cap_w       = cap_q;
`else
    assign cap_valid_w = 1'b0;
    assign cap_w       = '0;
`endif

    // ------------------------------------------------------------------
    // Decode and compare
    // ------------------------------------------------------------------
    assign wr_cmp    = bus_wen && (bus_addr == A_CMP);
    assign wr_period = bus_wen && (bus_addr == A_PERIOD);
    assign wr_ctrl   = bus_wen && (bus_addr == A_CTRL);
    assign wr_status = bus_wen && (bus_addr == A_STATUS);

    // Wrap-safe comparison: the modular difference, read as signed, is
    // non-negative once time_in has reached CMP (within half the range).
    assign delta = $signed(time_in - cmp_q);
    assign due   = (delta >= 0);

    always_comb begin
        rdata_d = '0;
        unique case (bus_addr)
            A_CMP:    rdata_d = cmp_q;
            A_PERIOD: rdata_d = period_q;
            A_CTRL:   rdata_d[1:0] = ctrl_q;
            A_STATUS: rdata_d[2:0] = {cap_valid_w, overrun_q, pending_q};
            A_NOW:    rdata_d = time_in;
            A_CAP:    rdata_d = cap_w;
            default:  rdata_d = '0;
        endcase
    end

    assign bus_rdata = rdata_q;
    assign irq       = pending_q;

    // ------------------------------------------------------------------
    // Registers and FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cmp_q       <= '0;
            period_q    <= '0;
            ctrl_q      <= '0;
            pending_q   <= 1'b0;
            overrun_q   <= 1'b0;
            rdata_q     <= '0;
`ifdef TIMER_CAPTURE_EN
            cap_s1_q    <= 1'b0;
            cap_s2_q    <= 1'b0;
            cap_s3_q    <= 1'b0;
            cap_q       <= '0;
            cap_valid_q <= 1'b0;
`endif
        end else begin
            if (bus_ren) begin
                rdata_q <= rdata_d;
            end

            if (wr_period) begin
                period_q <= bus_wdata;
            end
            if (wr_ctrl) begin
                ctrl_q <= bus_wdata[1:0];
            end
            if (wr_cmp) begin
                cmp_q <= bus_wdata;
            end

            // W1C clears come first so that a set later in this block
            // overrides a clear in the same cycle.
            if (wr_status) begin
                if (bus_wdata[0]) pending_q <= 1'b0;
                if (bus_wdata[1]) overrun_q <= 1'b0;
`ifdef TIMER_CAPTURE_EN
                if (bus_wdata[2]) cap_valid_q <= 1'b0;
`endif
            end

            unique case (state_q)
                IDLE: begin
                    if (wr_ctrl && bus_wdata[0]) begin
                        state_q <= ARMED;
                    end
                end
                ARMED: begin
                    // A CMP or CTRL write this cycle takes priority over
                    // firing; due is re-evaluated next cycle.
                    if (!wr_cmp && !wr_ctrl && due) begin
                        pending_q <= 1'b1;
                        if (pending_q) begin
                            overrun_q <= 1'b1;
                        end
                        if (ctrl_q[1] && (period_q != '0)) begin
                            cmp_q <= cmp_q + period_q;
                        end else begin
                            state_q <= FIRED;
                        end
                    end
                end
                FIRED: begin
                    if ((wr_cmp && ctrl_q[0]) || (wr_ctrl && bus_wdata[0])) begin
                        state_q <= ARMED;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (wr_ctrl && !bus_wdata[0]) begin
                state_q <= IDLE;
            end

`ifdef TIMER_CAPTURE_EN
            cap_s1_q <= capture_in;
            cap_s2_q <= cap_s1_q;
            cap_s3_q <= cap_s2_q;
            if (cap_rise) begin
                cap_q       <= time_in;
                cap_valid_q <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_timer_compare.sv
module tb_timer_compare;

    localparam int W  = 32;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  time_in;
    logic          bus_wen;
    logic          bus_ren;
    logic [AW-1:0] bus_addr;
    logic [W-1:0]  bus_wdata;
    logic [W-1:0]  bus_rdata;
    logic          irq;
`ifdef TIMER_CAPTURE_EN
    logic          capture_in;
`endif

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    string        tag_q[$];

    timer_compare #(.W(W), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .time_in   (time_in),
        .bus_wen   (bus_wen),
        .bus_ren   (bus_ren),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .irq       (irq)
`ifdef TIMER_CAPTURE_EN
        ,
        .capture_in(capture_in)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
        bus_addr  = a;
        bus_wdata = d;
        bus_wen   = 1'b1;
        cyc();
        bus_wen   = 1'b0;
    endtask

    // Expected value is queued when the read is issued and checked when
    // the registered read data appears.
    task automatic rd(input logic [AW-1:0] a, input logic [W-1:0] e, input string tag);
        logic [W-1:0] ev;
        string        tv;
        bus_addr = a;
        bus_ren  = 1'b1;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        cyc();
        bus_ren = 1'b0;
        ev = exp_q.pop_front();
        tv = tag_q.pop_front();
        chk(tv, bus_rdata, ev);
    endtask

    task automatic tick_irq(input logic [W-1:0] t, input logic e, input string tag);
        time_in = t;
        cyc();
        chk(tag, {31'd0, irq}, {31'd0, e});
    endtask

    initial begin
        logic [W-1:0] t;
        logic         e;

        rst       = 1'b1;
        time_in   = '0;
        bus_wen   = 1'b0;
        bus_ren   = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
`ifdef TIMER_CAPTURE_EN
        capture_in = 1'b0;
`endif
        repeat (2) cyc();
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_rdata", bus_rdata, 32'd0);
        rst = 1'b0;
        cyc();

        // Reset register values and map
        rd(3'd0, 32'd0, "rst_cmp");
        rd(3'd1, 32'd0, "rst_period");
        rd(3'd2, 32'd0, "rst_ctrl");
        rd(3'd3, 32'd0, "rst_status");
        rd(3'd5, 32'd0, "rst_cap");
        time_in = 32'd123;
        rd(3'd4, 32'd123, "now");
        wr(3'd4, 32'hDEAD_BEEF);
        wr(3'd6, 32'hFFFF_FFFF);
        rd(3'd4, 32'd123, "now_ro");
        rd(3'd6, 32'd0, "addr6");
        rd(3'd7, 32'd0, "addr7");

        // One-shot: fire at 100
        time_in = 32'd90;
        wr(3'd0, 32'd100);
        wr(3'd2, 32'd1);
        for (int i = 90; i < 100; i++) tick_irq(32'(i), 1'b0, "oneshot_pre");
        tick_irq(32'd100, 1'b1, "oneshot_fire");
        rd(3'd3, 32'd1, "oneshot_status");
        wr(3'd3, 32'd1);
        chk("oneshot_w1c", {31'd0, irq}, 32'd0);
        tick_irq(32'd105, 1'b0, "oneshot_fired_hold");
        tick_irq(32'd110, 1'b0, "oneshot_fired_hold2");
        rd(3'd0, 32'd100, "oneshot_cmp");

        // Wrap across rollover: CMP=5 from 0xFFFF_FFF0
        wr(3'd2, 32'd0);
        wr(3'd0, 32'd5);
        time_in = 32'hFFFF_FFF0;
        wr(3'd2, 32'd1);
        for (int i = 0; i < 23; i++) begin
            t = 32'hFFFF_FFF0 + 32'(i);
            e = (i >= 21);
            tick_irq(t, e, "wrap");
        end
        wr(3'd3, 32'd1);

        // Periodic: PERIOD=10, CMP=20
        wr(3'd2, 32'd0);
        wr(3'd3, 32'd7);
        time_in = 32'd15;
        wr(3'd1, 32'd10);
        wr(3'd0, 32'd20);
        wr(3'd2, 32'd3);
        for (int i = 15; i <= 45; i++) begin
            e = (i == 20) || (i == 30) || (i == 40);
            tick_irq(32'(i), e, "periodic");
            if (e) begin
                wr(3'd3, 32'd1);
                chk("periodic_w1c", {31'd0, irq}, 32'd0);
            end
        end
        rd(3'd3, 32'd0, "periodic_status");
        rd(3'd0, 32'd50, "periodic_cmp");

        // Catch-up: PERIOD=1, CMP behind time_in
        wr(3'd2, 32'd0);
        wr(3'd3, 32'd7);
        time_in = 32'd60;
        wr(3'd1, 32'd1);
        wr(3'd0, 32'd50);
        wr(3'd2, 32'd3);
        cyc();
        chk("catchup_irq", {31'd0, irq}, 32'd1);
        rd(3'd3, 32'd1, "catchup_status1");
        rd(3'd3, 32'd3, "catchup_overrun");
        repeat (10) cyc();
        rd(3'd0, 32'd61, "catchup_cmp");
        wr(3'd3, 32'd3);
        rd(3'd3, 32'd0, "catchup_cleared");

        // Periodic with PERIOD=0 acts as one-shot
        wr(3'd2, 32'd0);
        wr(3'd1, 32'd0);
        wr(3'd0, 32'd60);
        wr(3'd2, 32'd3);
        cyc();
        chk("p0_fire", {31'd0, irq}, 32'd1);
        wr(3'd3, 32'd1);
        cyc();
        cyc();
        chk("p0_no_refire", {31'd0, irq}, 32'd0);
        rd(3'd0, 32'd60, "p0_cmp");

        // CMP write on the due cycle wins
        wr(3'd2, 32'd0);
        time_in = 32'd95;
        wr(3'd0, 32'd100);
        wr(3'd2, 32'd1);
        for (int i = 96; i < 100; i++) tick_irq(32'(i), 1'b0, "cmpw_pre");
        time_in = 32'd100;
        wr(3'd0, 32'd200);
        chk("cmpw_wins", {31'd0, irq}, 32'd0);
        tick_irq(32'd101, 1'b0, "cmpw_new");
        tick_irq(32'd199, 1'b0, "cmpw_199");
        tick_irq(32'd200, 1'b1, "cmpw_fire200");

        // W1C on the fire cycle: set wins
        time_in = 32'd205;
        wr(3'd0, 32'd210);
        time_in = 32'd210;
        wr(3'd3, 32'd1);
        chk("set_beats_clear", {31'd0, irq}, 32'd1);
        rd(3'd3, 32'd3, "set_beats_clear_status");

        // Reset while ARMED
        wr(3'd3, 32'd7);
        wr(3'd1, 32'd100);
        wr(3'd0, 32'd300);
        wr(3'd2, 32'd3);
        tick_irq(32'd300, 1'b1, "pre_rst_fire");
        rd(3'd0, 32'd400, "pre_rst_cmp");
        rst = 1'b1;
        #2;
        chk("rst_async_irq", {31'd0, irq}, 32'd0);
        chk("rst_async_rdata", bus_rdata, 32'd0);
        cyc();
        rst = 1'b0;
        time_in = 32'd0;
        repeat (3) cyc();
        chk("idle_after_rst", {31'd0, irq}, 32'd0);
        rd(3'd0, 32'd0, "rst2_cmp");
        rd(3'd1, 32'd0, "rst2_period");
        rd(3'd2, 32'd0, "rst2_ctrl");
        rd(3'd3, 32'd0, "rst2_status");

`ifdef TIMER_CAPTURE_EN
        time_in = 32'd77;
        capture_in = 1'b1;
        repeat (4) cyc();
        capture_in = 1'b0;
        time_in = 32'd90;
        rd(3'd5, 32'd77, "cap_value");
        rd(3'd3, 32'd4, "cap_valid");
        wr(3'd3, 32'd4);
        rd(3'd3, 32'd0, "cap_valid_w1c");
`else
        time_in = 32'd77;
        rd(3'd5, 32'd0, "cap_disabled");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
